control_readback_tx: RTL and testbench

//  UART transmit side of the control interface. It serves host readback requests.
//  A line request reads one 128-byte row from frame RAM and sends it as "L", row, data.
//  The bytes use the same column order and address mapping as the line-write command path.
//  A status request sends "S", rgb_enable, brightness_enable, num_commands_processed.

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/uart_tx.sv | 65 ++++++
 rtl/control_readback_tx.sv | 189 ++++++++++++++++++
 tb/tb_control_readback_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Definitions shared by the control interface receive and readback paths:
// FSM states, command bytes and the frame-RAM line address mapping.
package ctrl_pkg;

    localparam int         LINE_BYTES = 128;
    localparam logic [7:0] CMD_LINE   = 8'h4C;  // "L"
    localparam logic [7:0] CMD_STATUS = 8'h53;  // "S"

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR0  = 4'd1,
        ST_HDR1  = 4'd2,
        ST_ST2   = 4'd3,
        ST_ST3   = 4'd4,
        ST_FETCH = 4'd5,
        ST_WAIT  = 4'd6,
        ST_SEND  = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // Column-to-RAM mapping used by the line-write path; readback must match it exactly.
    function automatic logic [11:0] line_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, ~col[6:1], col[0]};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer, LSB first, idles high. A load while idle starts the
// start bit on the next edge; busy covers start bit through end of stop bit.
module uart_tx #(
    parameter int TICKS_PER_BIT      = 9,
    parameter int TICKS_PER_BIT_SIZE = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_LAST = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_ONE  = TICKS_PER_BIT_SIZE'(1);

    logic [9:0]                    frame_q, frame_d;
    logic [3:0]                    bit_q, bit_d;
    logic [TICKS_PER_BIT_SIZE-1:0] tick_q, tick_d;
    logic                          busy_q, busy_d;

    always_comb begin
        frame_d = frame_q;
        bit_d   = bit_q;
        tick_d  = tick_q;
        busy_d  = busy_q;
        if (!busy_q) begin
            if (load) begin
                frame_d = {1'b1, data, 1'b0};
                bit_d   = 4'd0;
                tick_d  = '0;
                busy_d  = 1'b1;
            end
        end else if (tick_q == TICK_LAST) begin
            // Shift in ones so the line rests high once the stop bit is out.
            tick_d  = '0;
            frame_d = {1'b1, frame_q[9:1]};
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
            end
        end else begin
            tick_d = tick_q + TICK_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            frame_q <= '1;
            bit_q   <= 4'd0;
            tick_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            bit_q   <= bit_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = frame_q[0];
    assign busy = busy_q;

endmodule

// File: rtl/control_readback_tx.sv
// Control interface readback: answers line ("L") and status ("S") requests
// over UART, reading line data from the shared frame-RAM read port.
module control_readback_tx
    import ctrl_pkg::*;
#(
    parameter int UART_CLK_TICKS_PER_BIT = 9,
    parameter int UART_CLK_TICKS_WIDTH   = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_line,
    input  logic [4:0]  req_row,
    input  logic        req_status,
    input  logic [2:0]  rgb_enable,
    input  logic [5:0]  brightness_enable,
    input  logic [7:0]  num_commands_processed,
    input  logic [7:0]  ram_data_in,
    output logic [11:0] ram_address,
    output logic        ram_read_enable,
    output logic        uart_tx,
    output logic        tx_running,
    output logic        busy,
    output logic [7:0]  num_responses_sent
);

    state_t      state_q, state_d;
    logic        is_line_q, is_line_d;
    logic [4:0]  row_q, row_d;
    logic [2:0]  rgb_q, rgb_d;
    logic [5:0]  bright_q, bright_d;
    logic [7:0]  ncmd_q, ncmd_d;
    logic [6:0]  col_q, col_d;
    logic [7:0]  data_q, data_d;
    logic [11:0] ram_addr_q, ram_addr_d;
    logic        ram_re_q, ram_re_d;
    logic        busy_q, busy_d;
    logic [7:0]  resp_q, resp_d;

    logic        tx_load;
    logic [7:0]  tx_byte;
    logic        tx_busy;

    always_comb begin
        state_d    = state_q;
        is_line_d  = is_line_q;
        row_d      = row_q;
        rgb_d      = rgb_q;
        bright_d   = bright_q;
        ncmd_d     = ncmd_q;
        col_d      = col_q;
        data_d     = data_q;
        ram_addr_d = ram_addr_q;
        ram_re_d   = 1'b0;
        resp_d     = resp_q;
        tx_load    = 1'b0;
        tx_byte    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                // Line wins a same-cycle collision; the status pulse is simply lost.
                if (req_line) begin
                    is_line_d = 1'b1;
                    row_d     = req_row;
                    col_d     = 7'(LINE_BYTES - 1);
                    state_d   = ST_HDR0;
                end else if (req_status) begin
                    is_line_d = 1'b0;
                    rgb_d     = rgb_enable;
                    bright_d  = brightness_enable;
                    ncmd_d    = num_commands_processed;
                    state_d   = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    tx_byte = is_line_q ? CMD_LINE : CMD_STATUS;
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    if (is_line_q) begin
                        tx_byte    = {3'b000, row_q};
                        ram_re_d   = 1'b1;
                        ram_addr_d = line_addr(row_q, col_q);
                        state_d    = ST_FETCH;
                    end else begin
                        tx_byte = {5'b00000, rgb_q};
                        state_d = ST_ST2;
                    end
                end
            end
            ST_ST2: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    tx_byte = {2'b00, bright_q};
                    state_d = ST_ST3;
                end
            end
            ST_ST3: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    tx_byte = ncmd_q;
                    state_d = ST_DONE;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                data_d  = ram_data_in;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // The next read is only launched once this byte is in the serializer.
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    tx_byte = data_q;
                    if (col_q == 7'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        col_d      = col_q - 7'd1;
                        ram_re_d   = 1'b1;
                        ram_addr_d = line_addr(row_q, col_q - 7'd1);
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                if (!tx_busy) begin
                    resp_d  = resp_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_line_q  <= 1'b0;
            row_q      <= 5'd0;
            rgb_q      <= 3'd0;
            bright_q   <= 6'd0;
            ncmd_q     <= 8'd0;
            col_q      <= 7'd0;
            data_q     <= 8'd0;
            ram_addr_q <= 12'd0;
            ram_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            resp_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            is_line_q  <= is_line_d;
            row_q      <= row_d;
            rgb_q      <= rgb_d;
            bright_q   <= bright_d;
            ncmd_q     <= ncmd_d;
            col_q      <= col_d;
            data_q     <= data_d;
            ram_addr_q <= ram_addr_d;
            ram_re_q   <= ram_re_d;
            busy_q     <= busy_d;
            resp_q     <= resp_d;
        end
    end

    uart_tx #(
        .TICKS_PER_BIT      (UART_CLK_TICKS_PER_BIT),
        .TICKS_PER_BIT_SIZE (UART_CLK_TICKS_WIDTH)
    ) u_uart_tx (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (tx_load),
        .data   (tx_byte),
        .busy   (tx_busy),
        .tx     (uart_tx)
    );

    assign ram_address        = ram_addr_q;
    assign ram_read_enable    = ram_re_q;
    assign tx_running         = tx_busy;
    assign busy               = busy_q;
    assign num_responses_sent = resp_q;

endmodule

// File: tb/tb_control_readback_tx.sv
// Bench for control_readback_tx: expected UART bytes and RAM addresses are queued
// at stimulus time and checked by independent UART-decode and strobe monitors.
module tb_control_readback_tx;

    localparam int TPB = 9;
    localparam int MID = TPB / 2;

    logic        clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        reset;
    logic        req_line, req_status;
    logic [4:0]  req_row;
    logic [2:0]  rgb_enable;
    logic [5:0]  brightness_enable;
    logic [7:0]  num_commands_processed;
    logic [7:0]  ram_data_in;
    logic [11:0] ram_address;
    logic        ram_read_enable, uart_tx, tx_running, busy;
    logic [7:0]  num_responses_sent;

    // Second instance with a short bit time, used for the counter-wrap run.
    logic        w_req_status;
    logic [11:0] w_ram_address;
    logic        w_ram_read_enable, w_uart_tx, w_tx_running, w_busy;
    logic [7:0]  w_num_responses_sent;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [11:0] addr_q[$];
    int          rx_bytes = 0;
    int          strobes  = 0;
    logic [11:0] first_addr = 12'd0;
    logic [11:0] last_addr  = 12'd0;

    control_readback_tx #(.UART_CLK_TICKS_PER_BIT(TPB), .UART_CLK_TICKS_WIDTH(4)) u_dut (
        .clk_in(clk_in), .reset(reset), .req_line(req_line), .req_row(req_row),
        .req_status(req_status), .rgb_enable(rgb_enable), .brightness_enable(brightness_enable),
        .num_commands_processed(num_commands_processed), .ram_data_in(ram_data_in),
        .ram_address(ram_address), .ram_read_enable(ram_read_enable), .uart_tx(uart_tx),
        .tx_running(tx_running), .busy(busy), .num_responses_sent(num_responses_sent)
    );

    control_readback_tx #(.UART_CLK_TICKS_PER_BIT(3), .UART_CLK_TICKS_WIDTH(2)) u_wrap (
        .clk_in(clk_in), .reset(reset), .req_line(1'b0), .req_row(5'd0),
        .req_status(w_req_status), .rgb_enable(3'd1), .brightness_enable(6'd2),
        .num_commands_processed(8'd3), .ram_data_in(8'd0),
        .ram_address(w_ram_address), .ram_read_enable(w_ram_read_enable), .uart_tx(w_uart_tx),
        .tx_running(w_tx_running), .busy(w_busy), .num_responses_sent(w_num_responses_sent)
    );

    // Frame RAM model: synchronous read, contents mem[a] = a[7:0] ^ a[11:4].
    always @(posedge clk_in)
        if (ram_read_enable) ram_data_in <= ram_address[7:0] ^ ram_address[11:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_status(input logic [2:0] r, input logic [5:0] b, input logic [7:0] n);
        exp_q.push_back(8'h53);
        exp_q.push_back({5'b00000, r});
        exp_q.push_back({2'b00, b});
        exp_q.push_back(n);
    endtask

    task automatic push_line(input logic [4:0] row);
        logic [6:0]  c;
        logic [11:0] a;
        exp_q.push_back(8'h4C);
        exp_q.push_back({3'b000, row});
        for (int i = 127; i >= 0; i--) begin
            c = 7'(i);
            a = {row, ~c[6:1], c[0]};
            addr_q.push_back(a);
            exp_q.push_back(a[7:0] ^ a[11:4]);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({name, "_all_bytes"}, exp_q.size(), 32'd0);
    endtask

    // UART decoder: samples mid-bit on falling clock edges; frames hit by reset are dropped.
    initial begin : uart_mon
        logic [7:0] b;
        logic       ab, stop_bit;
        forever begin
            @(negedge clk_in);
            if (reset === 1'b0 && uart_tx === 1'b0) begin
                ab = 1'b0;
                b = 8'h00;
                stop_bit = 1'b0;
                for (int k = 1; k <= MID + 9 * TPB; k++) begin
                    @(negedge clk_in);
                    if (reset !== 1'b0) ab = 1'b1;
                    if (k >= MID + TPB && k <= MID + 8 * TPB && (k - MID) % TPB == 0)
                        b[(k - MID) / TPB - 1] = uart_tx;
                    if (k == MID + 9 * TPB) stop_bit = uart_tx;
                end
                if (!ab) begin
                    rx_bytes++;
                    check("stop_bit", {31'd0, stop_bit}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h expected none", b);
                    end else begin
                        check("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : len_mon
        int run;
        run = 0;
        forever begin
            @(negedge clk_in);
            if (reset !== 1'b0) run = 0;
            else if (tx_running === 1'b1) run++;
            else if (run != 0) begin
                check("frame_len", run, 10 * TPB);
                run = 0;
            end
        end
    end

    initial begin : strobe_mon
        forever begin
            @(negedge clk_in);
            if (reset === 1'b0 && ram_read_enable === 1'b1) begin
                strobes++;
                if (strobes == 1) first_addr = ram_address;
                last_addr = ram_address;
                if (addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %03h expected none", ram_address);
                end else begin
                    check("ram_addr", {20'd0, ram_address}, {20'd0, addr_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, n;
        reset = 1'b1;
        req_line = 1'b0; req_status = 1'b0; w_req_status = 1'b0; req_row = 5'd0;
        rgb_enable = 3'd0; brightness_enable = 6'd0; num_commands_processed = 8'd0;
        repeat (3) tick();
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_running", {31'd0, tx_running}, 32'd0);
        check("rst_ram_re", {31'd0, ram_read_enable}, 32'd0);
        check("rst_ram_addr", {20'd0, ram_address}, 32'd0);
        check("rst_count", {24'd0, num_responses_sent}, 32'd0);
        reset = 1'b0;
        repeat (5) tick();

        // 1: status response
        rgb_enable = 3'b101; brightness_enable = 6'h2A; num_commands_processed = 8'd7;
        push_status(3'b101, 6'h2A, 8'd7);
        req_status = 1'b1; tick(); req_status = 1'b0;
        check("t1_busy_rise", {31'd0, busy}, 32'd1);
        wait_done("t1", 600);
        check("t1_count", {24'd0, num_responses_sent}, 32'd1);

        // 2: line readback, row 5
        strobes = 0;
        req_row = 5'd5;
        push_line(5'd5);
        req_line = 1'b1; tick(); req_line = 1'b0;
        wait_done("t2", 14000);
        check("t2_strobes", strobes, 128);
        check("t2_first_addr", {20'd0, first_addr}, 32'h281);
        check("t2_last_addr", {20'd0, last_addr}, 32'h2FE);
        check("t2_addr_left", addr_q.size(), 0);
        check("t2_count", {24'd0, num_responses_sent}, 32'd2);

        // 3: same-cycle collision, then requests while busy are dropped
        strobes = 0;
        req_row = 5'd3;
        push_line(5'd3);
        req_line = 1'b1; req_status = 1'b1; tick(); req_line = 1'b0; req_status = 1'b0;
        repeat (10) tick();
        req_row = 5'd7;
        req_line = 1'b1; tick(); req_line = 1'b0;
        repeat (500) tick();
        req_status = 1'b1; tick(); req_status = 1'b0;
        wait_done("t3", 14000);
        repeat (200) tick();
        check("t3_idle", {31'd0, busy}, 32'd0);
        check("t3_strobes", strobes, 128);
        check("t3_count", {24'd0, num_responses_sent}, 32'd3);

        // 4: reset during data byte 40
        req_row = 5'd9;
        push_line(5'd9);
        base = rx_bytes;
        req_line = 1'b1; tick(); req_line = 1'b0;
        n = 0;
        while (rx_bytes < base + 42 && n < 6000) begin tick(); n++; end
        check("t4_reach_byte40", {31'd0, rx_bytes >= base + 42}, 32'd1);
        repeat (30) tick();
        reset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        tick();
        check("t4_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_tx_running", {31'd0, tx_running}, 32'd0);
        check("t4_ram_re", {31'd0, ram_read_enable}, 32'd0);
        check("t4_count", {24'd0, num_responses_sent}, 32'd0);
        reset = 1'b0;
        repeat (100) tick();
        rgb_enable = 3'b011; brightness_enable = 6'h15; num_commands_processed = 8'hC3;
        push_status(3'b011, 6'h15, 8'hC3);
        req_status = 1'b1; tick(); req_status = 1'b0;
        wait_done("t4_status", 600);
        check("t4_count_after", {24'd0, num_responses_sent}, 32'd1);

        // 5a: status inputs change mid-response; captured values are sent
        rgb_enable = 3'b110; brightness_enable = 6'h3F; num_commands_processed = 8'h80;
        push_status(3'b110, 6'h3F, 8'h80);
        req_status = 1'b1; tick(); req_status = 1'b0;
        rgb_enable = 3'b001; brightness_enable = 6'h01; num_commands_processed = 8'h01;
        repeat (150) tick();
        rgb_enable = 3'b010; brightness_enable = 6'h22; num_commands_processed = 8'h5A;
        wait_done("t5_snap", 600);
        check("t5_count", {24'd0, num_responses_sent}, 32'd2);

        // 5b: 256 status responses wrap the counter back to 0
        for (int i = 0; i < 256; i++) begin
            w_req_status = 1'b1; tick(); w_req_status = 1'b0;
            n = 0;
            while (w_busy !== 1'b0 && n < 400) begin tick(); n++; end
            if (n >= 400) begin
                n_tests++;
                n_fail++;
                $display("FAIL wrap_timeout: got busy at request %0d expected idle", i);
            end
            if (i == 0)   check("wrap_first", {24'd0, w_num_responses_sent}, 32'd1);
            if (i == 254) check("wrap_255", {24'd0, w_num_responses_sent}, 32'd255);
            if (i == 255) check("wrap_zero", {24'd0, w_num_responses_sent}, 32'd0);
        end
        check("wrap_idle_lines", {19'd0, w_ram_address, w_uart_tx, w_tx_running, w_ram_read_enable},
              {19'd0, 12'd0, 3'b100});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
